// File: rtl/xmint_pkg.sv
// Shared types and helpers for the xmint arbitration blocks.
package xmint_pkg;

   // Output-register occupancy state of the arbiter.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } xmint_state_e;

   // Modular increment used to walk requester indices in round-robin order.
   function automatic int wrap_add(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/xmint_mux.sv
// N-way payload multiplexer: selects one DataWidth slice of a packed bus.
module xmint_mux #(
   parameter int N            = 4,
   parameter int MuxDataWidth = 8
) (
   input  logic [N*MuxDataWidth-1:0] data_i,
   input  logic [$clog2(N)-1:0]      sel_i,
   output logic [MuxDataWidth-1:0]   data_o
);

   localparam int IW = $clog2(N);

   logic [MuxDataWidth-1:0] w_words [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign w_words[gi] = data_i[gi*MuxDataWidth +: MuxDataWidth];
      end
   endgenerate

   // Select the addressed word; an out-of-range select yields zero.
   always_comb begin
      data_o = '0;
      for (int k = 0; k < N; k++) begin
         if (sel_i == IW'(k)) begin
            data_o = w_words[k];
         end
      end
   end

endmodule

// File: rtl/xmint_rr_pick.sv
// Round-robin pick: first set request at or after (ptr_i+1) mod N, wrapping.
module xmint_rr_pick
   import xmint_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);

   localparam int IW = $clog2(N);

   // w_cand[gi] is the requester index examined at priority position gi.
   logic [IW-1:0] w_cand [N];
   logic [N-1:0]  w_rot;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rotate
         assign w_cand[gi] = IW'(wrap_add(int'(ptr_i), gi + 1, N));
         assign w_rot[gi]  = req_i[w_cand[gi]];
      end
   endgenerate

   // Priority encode the rotated vector; scanning downward lets the lowest
   // position (closest after the pointer) win.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            gnt_o           = '0;
            gnt_o[w_cand[k]] = 1'b1;
            idx_o           = w_cand[k];
            any_o           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xmint_rr_arbiter.sv
// Round-robin N:1 arbiter feeding a single registered output slot.
module xmint_rr_arbiter
   import xmint_pkg::*;
#(
   parameter int N         = 4,
   parameter int DataWidth = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [N-1:0]           req_valid_i,
   input  logic [N*DataWidth-1:0] req_data_i,
   output logic [N-1:0]           req_ready_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DataWidth-1:0]   out_data_o,
   output logic [$clog2(N)-1:0]   out_idx_o
);

   localparam int IW = $clog2(N);

   xmint_state_e         r_state;
   xmint_state_e         w_state_next;
   logic [IW-1:0]        r_last_ptr;
   logic [DataWidth-1:0] r_data;
   logic [IW-1:0]        r_idx;

   logic                 w_load;
   logic                 w_grant;
   logic [N-1:0]         w_pick_gnt;
   logic [IW-1:0]        w_pick_idx;
   logic                 w_pick_any;
   logic [DataWidth-1:0] w_mux_data;

   xmint_rr_pick #(
      .N (N)
   ) u_pick (
      .req_i (req_valid_i),
      .ptr_i (r_last_ptr),
      .gnt_o (w_pick_gnt),
      .idx_o (w_pick_idx),
      .any_o (w_pick_any)
   );

   xmint_mux #(
      .N            (N),
      .MuxDataWidth (DataWidth)
   ) u_mux (
      .data_i (req_data_i),
      .sel_i  (w_pick_idx),
      .data_o (w_mux_data)
   );

   // Next-state and handshake decode; a grant happens only in a load slot
   // and never while reset is held, so req_ready_o stays quiet in reset.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_grant      = 1'b0;
      req_ready_o  = '0;
      case (r_state)
         ST_EMPTY: w_load = 1'b1;
         ST_FULL:  w_load = out_ready_i;
         default:  w_load = 1'b0;
      endcase
      w_grant = w_load && w_pick_any && rst_ni;
      if (w_grant) begin
         w_state_next = ST_FULL;
         req_ready_o  = w_pick_gnt;
      end else if ((r_state == ST_FULL) && out_ready_i) begin
         w_state_next = ST_EMPTY;
      end
   end

   // State register; reset discards any word held in the output slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Output slot and pointer capture; the pointer starts at N-1 so that
   // requester 0 has first priority after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data     <= '0;
         r_idx      <= '0;
         r_last_ptr <= IW'(N - 1);
      end else if (w_grant) begin
         r_data     <= w_mux_data;
         r_idx      <= w_pick_idx;
         r_last_ptr <= w_pick_idx;
      end
   end

   assign out_valid_o = (r_state == ST_FULL);
   assign out_data_o  = r_data;
   assign out_idx_o   = r_idx;

endmodule

// File: tb/tb_xmint_rr_arbiter.sv
// Self-checking bench for xmint_rr_arbiter: directed scenarios plus a long
// randomized run against a behavioural round-robin reference model.
module tb_xmint_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic [N-1:0]    req_valid_i;
   logic [N*DW-1:0] req_data_i;
   logic [N-1:0]    req_ready_o;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [DW-1:0]   out_data_o;
   logic [IW-1:0]   out_idx_o;

   xmint_rr_arbiter #(
      .N         (N),
      .DataWidth (DW)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_idx_o   (out_idx_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: occupancy of the output slot, its contents, and the
   // index of the most recent grant.
   bit            m_full;
   logic [DW-1:0] m_data;
   int            m_idx;
   int            m_last;
   bit            verbose;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
   } word_t;
   word_t sb[$];
   int    n_granted;
   int    n_delivered;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Winner under round-robin: first valid requester after the last one
   // served, wrapping around; -1 if nobody asks.
   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int off = 1; off <= N; off++) begin
         int k;
         k = (last + off) % N;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_full      = 1'b0;
      m_data      = '0;
      m_idx       = 0;
      m_last      = N - 1;
      n_granted   = 0;
      n_delivered = 0;
      sb.delete();
   endtask

   // One clock cycle: check combinational and registered outputs against the
   // model with current inputs, advance the model, then cross the edge.
   task automatic step(output int g);
      logic [N-1:0] exp_rdy;
      word_t        w;
      #1;
      g = (!m_full || out_ready_i) ? rr_pick(req_valid_i, m_last) : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_val("req_ready", req_ready_o, exp_rdy);
      check_val("out_valid", out_valid_o, m_full);
      check_val("out_data", out_data_o, m_data);
      check_val("out_idx", out_idx_o, m_idx);
      if (m_full && out_ready_i) begin
         check_val("sb_nonempty", sb.size(), 1);
         if (sb.size() > 0) begin
            w = sb.pop_front();
            check_val("sb_data", out_data_o, w.data);
            check_val("sb_idx", out_idx_o, w.idx);
            n_delivered++;
         end
      end
      if (g >= 0) begin
         w.idx  = g;
         w.data = req_data_i[g*DW +: DW];
         sb.push_back(w);
         m_full = 1'b1;
         m_data = w.data;
         m_idx  = g;
         m_last = g;
         n_granted++;
         if (verbose) $display("grant idx=%0d data=%02h t=%0t", g, w.data, $time);
      end else if (m_full && out_ready_i) begin
         m_full = 1'b0;
      end
      @(posedge clk_i);
      #1;
   endtask

   int            g;
   int            exp_idx[5] = '{0, 1, 2, 3, 0};
   logic [DW-1:0] exp_dat[5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA};
   int            exp_wrap[3] = '{1, 3, 1};
   bit            rv[N];
   logic [DW-1:0] rd[N];
   int            wait_cnt[N];

   initial begin
      verbose     = 1'b1;
      rst_ni      = 1'b0;
      out_ready_i = 1'b1;
      req_valid_i = '1;
      req_data_i  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      model_reset();

      // Reset state, with every requester asking.
      repeat (2) @(posedge clk_i);
      #1;
      check_val("rst_valid", out_valid_o, 0);
      check_val("rst_data", out_data_o, 0);
      check_val("rst_idx", out_idx_o, 0);
      check_val("rst_ready", req_ready_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // All four valid: 0,1,2,3,0 one per cycle.
      for (int i = 0; i < 5; i++) begin
         step(g);
         check_val("seq_idx", out_idx_o, exp_idx[i]);
         check_val("seq_data", out_data_o, exp_dat[i]);
      end

      // Single requester 2 wins every slot.
      req_valid_i = 4'b0100;
      req_data_i  = {8'h00, 8'h5A, 8'h00, 8'h00};
      for (int i = 0; i < 4; i++) begin
         step(g);
         check_val("solo_grant", g, 2);
         check_val("solo_data", out_data_o, 8'h5A);
         check_val("solo_idx", out_idx_o, 2);
      end

      // Stall: downstream not ready, requester 1 waits.
      out_ready_i = 1'b0;
      req_valid_i = 4'b0010;
      req_data_i  = {8'h00, 8'h00, 8'h11, 8'h00};
      for (int i = 0; i < 3; i++) begin
         step(g);
         check_val("stall_valid", out_valid_o, 1);
         check_val("stall_data", out_data_o, 8'h5A);
      end
      out_ready_i = 1'b1;
      step(g);
      check_val("resume_grant", g, 1);
      check_val("resume_data", out_data_o, 8'h11);

      // Put the pointer on 3, then alternate between 1 and 3.
      req_valid_i = 4'b1000;
      req_data_i  = {8'h33, 8'h00, 8'h11, 8'h00};
      step(g);
      check_val("ptr3_grant", g, 3);
      req_valid_i = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         step(g);
         check_val("wrap_idx", out_idx_o, exp_wrap[i]);
      end

      // Asynchronous reset while FULL.
      rst_ni = 1'b0;
      #2;
      check_val("arst_valid", out_valid_o, 0);
      check_val("arst_ready", req_ready_o, 0);
      check_val("arst_idx", out_idx_o, 0);
      model_reset();
      @(negedge clk_i);
      rst_ni      = 1'b1;
      req_valid_i = '1;
      req_data_i  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      step(g);
      check_val("post_rst_grant", g, 0);
      check_val("post_rst_idx", out_idx_o, 0);

      // Randomized run: sticky requests, random backpressure.
      verbose = 1'b0;
      for (int k = 0; k < N; k++) begin
         rv[k]       = 1'b0;
         rd[k]       = '0;
         wait_cnt[k] = 0;
      end
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!rv[k] && ($urandom_range(0, 2) == 0)) begin
               rv[k]       = 1'b1;
               rd[k]       = DW'($urandom);
               wait_cnt[k] = 0;
            end
            req_valid_i[k]           = rv[k];
            req_data_i[k*DW +: DW]   = rd[k];
         end
         out_ready_i = ($urandom_range(0, 3) != 0);
         step(g);
         if (g >= 0) begin
            check_val("fair_gap_ok", (wait_cnt[g] <= N - 1), 1);
            for (int k = 0; k < N; k++) begin
               if (k != g && rv[k]) wait_cnt[k]++;
            end
            rv[g] = 1'b0;
         end
      end

      // Drain and account for every word.
      req_valid_i = '0;
      out_ready_i = 1'b1;
      repeat (3) step(g);
      check_val("no_lost_words", n_delivered, n_granted);
      check_val("drained", out_valid_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xmint_rr_arbiter.md
XMINT_RR_ARBITER -- requirements
Module: xmint_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (legal range 2..16).
REQ-002 SHALL have parameter DataWidth, default 8, payload width per requester.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i, input, N, bit k set = requester k offers a word.
REQ-006 SHALL have port req_data_i, input, N*DataWidth, requester k payload in bits [k*DataWidth +: DataWidth].
REQ-007 SHALL have port req_ready_o, output, N, bit k set = requester k's word accepted this cycle.
REQ-008 SHALL have port out_valid_o, output, 1, output register holds a word.
REQ-009 SHALL have port out_ready_i, input, 1, downstream accepts the word.
REQ-010 SHALL have port out_data_o, output, DataWidth, registered granted payload.
REQ-011 SHALL have port out_idx_o, output, $clog2(N), index of the requester that supplied out_data_o.

Function
REQ-012 SHALL implement a two-state FSM: EMPTY (out_valid_o=0) and FULL (out_valid_o=1).
REQ-013 SHALL define "load slot" as state EMPTY, or state FULL with out_ready_i=1.
REQ-014 SHALL, in a load slot with any req_valid_i set, grant exactly one requester: the first set bit at or after index (last_ptr+1) mod N, wrapping.
REQ-015 SHALL assert req_ready_o only for the granted bit, same cycle, combinationally from req_valid_i, state, out_ready_i and last_ptr; never for a non-valid bit.
REQ-016 SHALL drive req_ready_o to all-zero outside load slots.
REQ-017 SHALL, on a grant, capture the granted payload into out_data_o and its index into out_idx_o at the next edge, set last_ptr to the granted index, and go to or stay in FULL; latency is exactly 1 cycle.
REQ-018 SHALL, in FULL with out_ready_i=1 and no req_valid_i, go to EMPTY; out_data_o/out_idx_o hold their last values.
REQ-019 SHALL, in FULL with out_ready_i=0, hold out_valid_o, out_data_o and out_idx_o stable.
REQ-020 SHALL sustain one transfer per cycle when out_ready_i is held at 1 and requests are continuous.
REQ-021 SHALL update last_ptr only on a grant; an idle cycle does not move the pointer.
REQ-022 SHALL guarantee fairness: with all N requesters continuously valid, each is granted exactly once in every N consecutive grants.
REQ-023 SHALL, with a single active requester, grant it on every load slot regardless of last_ptr.
REQ-024 SHALL not combinationally depend on req_data_i for any control output.

Reset
REQ-025 SHALL, while rst_ni=0, force state EMPTY, out_valid_o=0, out_data_o=0, out_idx_o=0, and last_ptr=N-1, so requester 0 wins first.
REQ-026 SHALL drive req_ready_o to 0 while rst_ni=0.
REQ-027 SHALL discard a FULL word on reset assertion mid-operation; no grant occurs on the edge reset is released.

Structure
REQ-028 SHALL take the FSM state enum (EMPTY, FULL) from shared package xmint_pkg.
REQ-029 SHALL instantiate the existing xmint_mux (N, MuxDataWidth=DataWidth) for payload selection, with sel_i driven by the grant index.
REQ-030 SHALL implement the rotate-and-priority-pick as one sub-module, xmint_rr_pick: inputs req vector and pointer, outputs one-hot grant and its index.

Verification
REQ-031 SHALL cover: reset, then all four valid with data AA/BB/CC/DD and out_ready_i=1 -> out_idx_o sequence 0,1,2,3,0, data AA,BB,CC,DD,AA, one per cycle.
REQ-032 SHALL cover: only requester 2 valid (data 5A) for 4 cycles, out_ready_i=1 -> req_ready_o=0100 each cycle, out_data_o=5A, out_idx_o=2.
REQ-033 SHALL cover: FULL with out_ready_i=0 for 3 cycles while requester 1 valid -> req_ready_o=0000, out_data_o stable; then out_ready_i=1 -> requester 1 granted that cycle.
REQ-034 SHALL cover: last_ptr=3, requesters 1 and 3 valid -> grant 1, then 3, then 1 (wrap-around).
REQ-035 SHALL cover: rst_ni pulsed low while FULL -> out_valid_o=0 immediately (asynchronous), first post-reset grant goes to requester 0 when all valid.
REQ-036 SHALL cover: random valid and out_ready_i over 10000 cycles -> scoreboard shows no lost/duplicated words and at most N-1 grants to others between any two grants to a continuously valid requester.
